long_wb_arbiter: RTL and testbench

LONG_WB_ARBITER -- requirements
Module: long_wb_arbiter

---
 rtl/riscv_wb_pkg.sv | 17 +
 rtl/wb_fifo.sv | 47 ++++
 rtl/long_wb_arbiter.sv | 106 ++++++++++
 tb/tb_long_wb_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_wb_pkg.sv
// rtl/riscv_wb_pkg.sv - shared writeback types: source encoding, result entry, widths
package riscv_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef enum logic {
        WB_SRC_LOAD = 1'b0,
        WB_SRC_MULT = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-source result buffer; extra pointer bit separates full from empty
module wb_fifo
    import riscv_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      empty,
    output logic      full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    wb_entry_t        mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head  = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[PTR_W-1:0]] <= push_entry;
    end

endmodule

// File: rtl/long_wb_arbiter.sv
// rtl/long_wb_arbiter.sv - merges multiplier/load results onto the spare regfile write port (LONG_WB_ROUND_ROBIN_EN selects round-robin)
module long_wb_arbiter
    import riscv_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  mult_vld,
    output logic                  mult_rdy,
    input  logic [REG_ADDR_W-1:0] mult_rd,
    input  logic [XLEN-1:0]       mult_data,
    input  logic                  load_vld,
    output logic                  load_rdy,
    input  logic [REG_ADDR_W-1:0] load_rd,
    input  logic [XLEN-1:0]       load_data,
    input  logic                  alu_wb,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  MULT_reg_wr,
    output logic [REG_ADDR_W-1:0] MULT_reg_rd,
    output logic                  LOAD_reg_wr,
    output logic [REG_ADDR_W-1:0] LOAD_reg_rd
);

    wb_entry_t mult_in, load_in, mult_head, load_head, pop_entry;
    logic      mult_empty, mult_full, load_empty, load_full;
    logic      pop, mult_pop, load_pop;
    wb_src_e   grant_src;

    assign mult_in  = {mult_rd, mult_data};
    assign load_in  = {load_rd, load_data};
    assign mult_rdy = ~mult_full;
    assign load_rdy = ~load_full;

    wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_mult_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (mult_vld & mult_rdy),
        .push_entry (mult_in),
        .pop        (mult_pop),
        .head       (mult_head),
        .empty      (mult_empty),
        .full       (mult_full)
    );

    wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_load_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (load_vld & load_rdy),
        .push_entry (load_in),
        .pop        (load_pop),
        .head       (load_head),
        .empty      (load_empty),
        .full       (load_full)
    );

`ifdef LONG_WB_ROUND_ROBIN_EN
    wb_src_e last_grant;

    // Reset to MULT so the first contested grant goes to LOAD.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            last_grant <= WB_SRC_MULT;
        else if (pop)
            last_grant <= grant_src;
    end

    assign grant_src = (!load_empty && (mult_empty || last_grant == WB_SRC_MULT))
                       ? WB_SRC_LOAD : WB_SRC_MULT;
`else
    assign grant_src = !load_empty ? WB_SRC_LOAD : WB_SRC_MULT;
`endif

    assign pop       = !alu_wb && !(load_empty && mult_empty);
    assign load_pop  = pop && (grant_src == WB_SRC_LOAD);
    assign mult_pop  = pop && (grant_src == WB_SRC_MULT);
    assign pop_entry = (grant_src == WB_SRC_LOAD) ? load_head : mult_head;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            MULT_reg_wr <= 1'b0;
            MULT_reg_rd <= '0;
            LOAD_reg_wr <= 1'b0;
            LOAD_reg_rd <= '0;
        end else begin
            // x0 is never written but its scoreboard entry must still clear.
            rf_we       <= pop && (pop_entry.rd != '0);
            MULT_reg_wr <= mult_pop;
            LOAD_reg_wr <= load_pop;
            if (pop) begin
                rf_waddr <= pop_entry.rd;
                rf_wdata <= pop_entry.data;
            end
            if (mult_pop)
                MULT_reg_rd <= pop_entry.rd;
            if (load_pop)
                LOAD_reg_rd <= pop_entry.rd;
        end
    end

endmodule

// File: tb/tb_long_wb_arbiter.sv
// tb/tb_long_wb_arbiter.sv - queue-model checked directed bench for long_wb_arbiter
module tb_long_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mult_vld = 1'b0, load_vld = 1'b0, alu_wb = 1'b0;
    logic [4:0]  mult_rd = '0, load_rd = '0;
    logic [31:0] mult_data = '0, load_data = '0;
    logic        mult_rdy, load_rdy, rf_we, MULT_reg_wr, LOAD_reg_wr;
    logic [4:0]  rf_waddr, MULT_reg_rd, LOAD_reg_rd;
    logic [31:0] rf_wdata;

    int n_cmp = 0;
    int n_err = 0;

    long_wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .mult_vld    (mult_vld),
        .mult_rdy    (mult_rdy),
        .mult_rd     (mult_rd),
        .mult_data   (mult_data),
        .load_vld    (load_vld),
        .load_rdy    (load_rdy),
        .load_rd     (load_rd),
        .load_data   (load_data),
        .alu_wb      (alu_wb),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .MULT_reg_wr (MULT_reg_wr),
        .MULT_reg_rd (MULT_reg_rd),
        .LOAD_reg_wr (LOAD_reg_wr),
        .LOAD_reg_rd (LOAD_reg_rd)
    );

    always #5 clk = ~clk;

    // Model: one queue per source, one pop per free cycle, result visible after the edge.
    logic [36:0] lq[$];
    logic [36:0] mq[$];
    logic        m_we = 1'b0, m_mwr = 1'b0, m_lwr = 1'b0;
    logic [4:0]  m_waddr = '0, m_mrd = '0, m_lrd = '0;
    logic [31:0] m_wdata = '0;
    bit          m_last_mult = 1'b1;
    int          ls, ms;
    bit          take_load;
    logic [36:0] me;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lq.delete(); mq.delete();
            m_we = 0; m_mwr = 0; m_lwr = 0;
            m_waddr = 0; m_wdata = 0; m_mrd = 0; m_lrd = 0;
            m_last_mult = 1'b1;
        end else begin
            ls = lq.size();
            ms = mq.size();
            m_we = 0; m_mwr = 0; m_lwr = 0;
            if (!alu_wb && (ls > 0 || ms > 0)) begin
`ifdef LONG_WB_ROUND_ROBIN_EN
                take_load = (ls > 0 && ms > 0) ? m_last_mult : (ls > 0);
`else
                take_load = (ls > 0);
`endif
                me = take_load ? lq.pop_front() : mq.pop_front();
                m_last_mult = !take_load;
                m_waddr = me[36:32];
                m_wdata = me[31:0];
                m_we    = (me[36:32] != 0);
                if (take_load) begin m_lwr = 1; m_lrd = me[36:32]; end
                else           begin m_mwr = 1; m_mrd = me[36:32]; end
            end
            if (load_vld && ls < DEPTH) lq.push_back({load_rd, load_data});
            if (mult_vld && ms < DEPTH) mq.push_back({mult_rd, mult_data});
        end
    end

    logic [51:0] got_v, exp_v;
    byte         grant_log[$];
    logic [4:0]  mult_log[$];
    int          pulse_cnt = 0;

    always @(negedge clk) begin
        got_v = {rf_we, rf_waddr, rf_wdata, MULT_reg_wr, MULT_reg_rd,
                 LOAD_reg_wr, LOAD_reg_rd, mult_rdy, load_rdy};
        exp_v = {m_we, m_waddr, m_wdata, m_mwr, m_mrd, m_lwr, m_lrd,
                 mq.size() < DEPTH, lq.size() < DEPTH};
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL model_cycle t=%0t got=%h expected=%h", $time, got_v, exp_v);
        end
        if (LOAD_reg_wr) begin grant_log.push_back("L"); pulse_cnt++; end
        if (MULT_reg_wr) begin grant_log.push_back("M"); mult_log.push_back(MULT_reg_rd); pulse_cnt++; end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    bit accepted;

    initial begin
        tick(); tick();
        @(negedge clk);
        check("reset_rf_we", 32'(rf_we), 0);
        check("reset_rdy", 32'({mult_rdy, load_rdy}), 32'h3);
        tick();
        rstn = 1'b1;

        // Collision: load wins first in both priority schemes.
        mult_vld = 1; mult_rd = 7; mult_data = 32'h70;
        load_vld = 1; load_rd = 9; load_data = 32'h90;
        tick();
        mult_vld = 0; load_vld = 0;
        tick();
        @(negedge clk);
        check("coll_first_addr", 32'(rf_waddr), 9);
        check("coll_first_lwr", 32'({LOAD_reg_wr, MULT_reg_wr}), 32'h2);
        tick();
        @(negedge clk);
        check("coll_second_addr", 32'(rf_waddr), 7);
        check("coll_second_mwr", 32'({LOAD_reg_wr, MULT_reg_wr, MULT_reg_rd}), 32'h27);
        tick(); tick();

        // Single load, two-cycle latency.
        load_vld = 1; load_rd = 5; load_data = 32'hDEADBEEF;
        tick();
        load_vld = 0;
        tick();
        @(negedge clk);
        check("single_we_addr", 32'({rf_we, rf_waddr}), 32'h25);
        check("single_data", rf_wdata, 32'hDEADBEEF);
        check("single_release", 32'({LOAD_reg_wr, LOAD_reg_rd}), 32'h25);
        tick();
        @(negedge clk);
        check("single_pulse_end", 32'({rf_we, LOAD_reg_wr}), 0);
        tick();

        // x0 result: release without write.
        load_vld = 1; load_rd = 0; load_data = 32'h1234;
        tick();
        load_vld = 0;
        tick();
        @(negedge clk);
        check("x0_rf_we", 32'(rf_we), 0);
        check("x0_release", 32'({LOAD_reg_wr, LOAD_reg_rd}), 32'h20);
        tick(); tick();

        // Backpressure: port busy while three mult results arrive.
        mult_log.delete();
        alu_wb = 1;
        mult_vld = 1; mult_rd = 1; mult_data = 32'h11;
        tick();
        mult_rd = 2; mult_data = 32'h22;
        tick();
        check("bp_rdy_low", 32'(mult_rdy), 0);
        mult_rd = 3; mult_data = 32'h33;
        tick(); tick();
        alu_wb = 0;
        accepted = 0;
        for (int i = 0; i < 8 && !accepted; i++) begin
            if (mult_rdy) accepted = 1;
            tick();
        end
        mult_vld = 0;
        check("bp_third_accepted", 32'(accepted), 1);
        for (int i = 0; i < 6; i++) tick();
        check("bp_count", mult_log.size(), 3);
        if (mult_log.size() == 3) begin
            check("bp_order0", 32'(mult_log[0]), 1);
            check("bp_order1", 32'(mult_log[1]), 2);
            check("bp_order2", 32'(mult_log[2]), 3);
        end

        // Fairness: both sources kept busy.
        alu_wb = 1;
        load_vld = 1; mult_vld = 1;
        for (int i = 0; i < 2; i++) begin
            load_rd = 5'(10 + i); load_data = 32'(100 + i);
            mult_rd = 5'(20 + i); mult_data = 32'(200 + i);
            tick();
        end
        alu_wb = 0;
        grant_log.delete();
        for (int i = 0; i < 8; i++) begin
            load_rd = 5'(12 + i); load_data = 32'(102 + i);
            mult_rd = 5'(22 + (i % 8)); mult_data = 32'(202 + i);
            tick();
        end
        load_vld = 0; mult_vld = 0;
        @(negedge clk);
        #1;
        check("fair_count", 32'(grant_log.size() >= 8), 1);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
`ifdef LONG_WB_ROUND_ROBIN_EN
            check($sformatf("fair_grant%0d", i), 32'(grant_log[i]), (i % 2 == 0) ? 32'h4C : 32'h4D);
`else
            check($sformatf("fair_grant%0d", i), 32'(grant_log[i]), 32'h4C);
`endif
        end
        for (int i = 0; i < 10; i++) tick();

        // Reset mid-stream with two entries buffered.
        alu_wb = 1;
        mult_vld = 1; mult_rd = 4; mult_data = 32'h44;
        load_vld = 1; load_rd = 6; load_data = 32'h66;
        tick();
        mult_vld = 0; load_vld = 0;
        tick();
        rstn = 0;
        alu_wb = 0;
        tick();
        rstn = 1;
        pulse_cnt = 0;
        @(negedge clk);
        check("rst_rdy_after", 32'({mult_rdy, load_rdy}), 32'h3);
        for (int i = 0; i < 6; i++) tick();
        check("rst_no_release", pulse_cnt, 0);
        check("rst_no_write", 32'(rf_we), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
